// File: rtl/reg_wb_queue.sv
// Register-file write-back merger: ALU results take the write port first, long-latency
// results wait in an in-order queue. Optional forwarding is enabled by defining WB_BYPASS_EN.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic [4:0]               q_rd,
    output logic                     pend_hit,
    output logic [XLEN-1:0]          q_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     RegWEn,
    output logic [4:0]               AddrD,
    output logic [XLEN-1:0]          DataD
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_wen;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_wdata;

    logic             w_alu_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_push_vld;
    logic [DEPTH-1:0] w_vld_next;

    assign w_alu_wr   = alu_valid && (alu_rd != 5'd0);
    assign mem_ready  = rst_n && (r_count < CW'(DEPTH));
    // Writes to x0 complete the handshake but never occupy a slot.
    assign w_push     = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign w_pop      = !w_alu_wr && (r_count != '0);
    assign w_push_vld = !(w_alu_wr && (alu_rd == mem_rd));

    // An ALU write is always the youngest result, so it squashes queued entries for the same rd.
    always_comb begin
        w_vld_next = r_vld;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_wr && (r_rd[i] == alu_rd)) begin
                w_vld_next[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_vld_next[r_head] = 1'b0;
        end
        if (w_push) begin
            w_vld_next[r_tail] = w_push_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            r_vld <= w_vld_next;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= mem_rd;
            r_data[r_tail] <= mem_data;
        end
    end

    // A squashed head still consumes its pop cycle; address and data hold in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_alu_wr) begin
            r_wen   <= 1'b1;
            r_addr  <= alu_rd;
            r_wdata <= alu_data;
        end else if (w_pop) begin
            r_wen <= r_vld[r_head];
            if (r_vld[r_head]) begin
                r_addr  <= r_rd[r_head];
                r_wdata <= r_data[r_head];
            end
        end else begin
            r_wen <= 1'b0;
        end
    end

    assign RegWEn = r_wen;
    assign AddrD  = r_addr;
    assign DataD  = r_wdata;
    assign count  = r_count;

`ifdef WB_BYPASS_EN
    logic            w_q_hit;
    logic [XLEN-1:0] w_q_dat;
    logic [AW-1:0]   w_idx;
    logic            w_out_hit;

    // Walk from oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_q_hit = 1'b0;
        w_q_dat = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + AW'(k);
            if (r_vld[w_idx] && (r_rd[w_idx] == q_rd)) begin
                w_q_hit = 1'b1;
                w_q_dat = r_data[w_idx];
            end
        end
    end

    assign w_out_hit = r_wen && (r_addr == q_rd);
    assign pend_hit  = (q_rd != 5'd0) && (w_q_hit || w_out_hit);
    assign q_data    = (q_rd == 5'd0) ? '0 :
                       w_q_hit        ? w_q_dat :
                       w_out_hit      ? r_wdata : '0;
`else
    logic w_q_hit;

    always_comb begin
        w_q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == q_rd)) begin
                w_q_hit = 1'b1;
            end
        end
    end

    assign pend_hit = (q_rd != 5'd0) && w_q_hit;
    assign q_data   = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a behavioural queue model predicts every write-port
// update, and expected writes are scoreboarded against RegWEn/AddrD/DataD.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            mem_valid = 1'b0;
    logic            mem_ready;
    logic [4:0]      mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic [4:0]      q_rd = '0;
    logic            pend_hit;
    logic [XLEN-1:0] q_data;
    logic [$clog2(DEPTH):0] count;
    logic            RegWEn;
    logic [4:0]      AddrD;
    logic [XLEN-1:0] DataD;

    reg_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .q_rd(q_rd), .pend_hit(pend_hit), .q_data(q_data), .count(count),
        .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            v;
    } ent_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    ent_t modelQ[$];
    wr_t  expWrites[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic            mRegWEn = 1'b0;
    logic [4:0]      mAddrD = '0;
    logic [XLEN-1:0] mDataD = '0;

    task automatic compare(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predicts what the coming clock edge does, using the inputs currently driven.
    task automatic modelEdge();
        logic aluWr;
        logic accept;
        ent_t e;
        wr_t  w;
        aluWr   = alu_valid && (alu_rd != 5'd0);
        accept  = mem_valid && (modelQ.size() < DEPTH);
        mRegWEn = 1'b0;
        if (aluWr) begin
            foreach (modelQ[i]) if (modelQ[i].rd == alu_rd) modelQ[i].v = 1'b0;
            w.rd = alu_rd; w.data = alu_data;
            expWrites.push_back(w);
            mRegWEn = 1'b1; mAddrD = alu_rd; mDataD = alu_data;
        end else if (modelQ.size() > 0) begin
            e = modelQ.pop_front();
            if (e.v) begin
                w.rd = e.rd; w.data = e.data;
                expWrites.push_back(w);
                mRegWEn = 1'b1; mAddrD = e.rd; mDataD = e.data;
            end
        end
        if (accept && (mem_rd != 5'd0)) begin
            e.rd = mem_rd; e.data = mem_data;
            e.v  = !(aluWr && (mem_rd == alu_rd));
            modelQ.push_back(e);
        end
    endtask

    task automatic checkOutput();
        logic            qHit;
        logic [XLEN-1:0] qDat;
        logic            outHit;
        logic            expPend;
        logic [XLEN-1:0] expQData;
        wr_t             w;
        compare("RegWEn", {31'd0, RegWEn}, {31'd0, mRegWEn});
        if (RegWEn === 1'b1) begin
            if (expWrites.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected_write: observed AddrD=%0d expected no write", AddrD);
            end else begin
                w = expWrites.pop_front();
                compare("sb_AddrD", {27'd0, AddrD}, {27'd0, w.rd});
                compare("sb_DataD", DataD, w.data);
            end
        end
        compare("AddrD", {27'd0, AddrD}, {27'd0, mAddrD});
        compare("DataD", DataD, mDataD);
        compare("count", XLEN'(count), XLEN'(modelQ.size()));
        compare("mem_ready", {31'd0, mem_ready}, {31'd0, rst_n && (modelQ.size() < DEPTH)});
        qHit = 1'b0;
        qDat = '0;
        foreach (modelQ[i]) begin
            if (modelQ[i].v && (modelQ[i].rd == q_rd)) begin
                qHit = 1'b1;
                qDat = modelQ[i].data;
            end
        end
        outHit   = mRegWEn && (mAddrD == q_rd);
        expPend  = (q_rd != 5'd0) && (qHit || (BYP && outHit));
        expQData = (!BYP || q_rd == 5'd0) ? '0 : qHit ? qDat : outHit ? mDataD : '0;
        compare("pend_hit", {31'd0, pend_hit}, {31'd0, expPend});
        compare("q_data", q_data, expQData);
    endtask

    task automatic tick();
        if (rst_n) modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                                 input logic mv, input logic [4:0] mr, input logic [XLEN-1:0] md,
                                 input logic [4:0] qr);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        q_rd = qr;
    endtask

    task automatic modelReset();
        modelQ.delete();
        expWrites.delete();
        mRegWEn = 1'b0; mAddrD = '0; mDataD = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        modelReset();
        tick();
        tick();
        compare("reset_RegWEn", {31'd0, RegWEn}, 32'd0);
        compare("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput();

        // 1: single ALU write, one-cycle latency
        applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, '0, 5'd5);
        tick();
        compare("t1_AddrD", {27'd0, AddrD}, 32'd5);
        compare("t1_DataD", DataD, 32'h0000_1234);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
        tick();
        compare("t1_RegWEn_low", {31'd0, RegWEn}, 32'd0);

        // 2: one long-latency result, enqueue edge then pop edge
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd3, 32'hAA, 5'd3);
        tick();
        compare("t2_pend", {31'd0, pend_hit}, 32'd1);
        compare("t2_no_write", {31'd0, RegWEn}, 32'd0);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd3);
        tick();
        compare("t2_RegWEn", {31'd0, RegWEn}, 32'd1);
        compare("t2_DataD", DataD, 32'hAA);
        tick();

        // 3: fill the queue behind a busy ALU, then drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(8 + i), 32'hC0 + i, 5'd9);
            tick();
        end
        compare("t3_full_ready", {31'd0, mem_ready}, 32'd0);
        compare("t3_full_count", XLEN'(count), 32'd4);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            compare("t3_drain_addr", {27'd0, AddrD}, 32'(8 + i));
            if (i == 0) compare("t3_ready_back", {31'd0, mem_ready}, 32'd1);
        end
        tick();

        // 4: WAW squash of a queued entry by a younger ALU write
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'h55, 5'd7);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h66, 1'b0, 5'd0, '0, 5'd7);
        tick();
        compare("t4_pend", {31'd0, pend_hit}, {31'd0, BYP});
        compare("t4_DataD", DataD, 32'h66);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7);
        tick();
        compare("t4_squash_pop", {31'd0, RegWEn}, 32'd0);
        compare("t4_count", XLEN'(count), 32'd0);

        // 5: x0 destinations are never written
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0);
        tick();
        tick();
        compare("t5_RegWEn", {31'd0, RegWEn}, 32'd0);
        compare("t5_count", XLEN'(count), 32'd0);

        // 6: same rd queued twice, then a third entry, then reset mid-drain
        applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h10, 5'd4);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h20, 5'd4);
        tick();
        compare("t6_q_data", q_data, BYP ? 32'h20 : 32'h0);
        applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd6, 32'h30, 5'd4);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd4);
        tick();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        compare("t6_rst_DataD", DataD, 32'd0);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h99, 5'd5);
        tick();
        tick();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd6);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        compare("t6_after_count", XLEN'(count), 32'd0);

        compare("sb_drained", XLEN'(expWrites.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
